// File: rtl/lfsr_range_sampler_pkg.sv
// Shared types, default sizes and the mask helper for the LFSR range sampler.
package lfsr_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  localparam int DEFAULT_DATA_W     = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_CNT_W      = 16;

  // Smallest all-ones mask covering limit-1, confined to the low 'width' bits.
  // A limit of 0 stands for the full 2^width range and yields all ones.
  function automatic logic [31:0] range_mask(input logic [31:0] limit, input int width);
    logic [31:0] top;
    logic [31:0] m;
    top = limit - 32'd1;
    m   = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) m[i] = (limit == 32'd0) || (|(top >> i));
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_range_sampler_if.sv
// Sampler bus: LFSR word in, limit control, valid/ready sample out, status.
interface lfsr_range_sampler_if
  import lfsr_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
);
  logic [31:0]       rand_in;
  logic              rand_en;
  logic [DATA_W-1:0] limit;
  logic              limit_load;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  reject_cnt;
  logic              busy;

  // Environment side: supplies words and limits, consumes samples.
  modport master (
    output rand_in, rand_en, limit, limit_load, out_ready,
    input  out_data, out_valid, reject_cnt, busy
  );

  // Sampler side.
  modport slave (
    input  rand_in, rand_en, limit, limit_load, out_ready,
    output out_data, out_valid, reject_cnt, busy
  );
endinterface

// File: rtl/lfsr_range_sampler_fifo.sv
// Show-ahead sample FIFO with synchronous flush and occupancy output.
module sample_fifo
  import lfsr_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int COUNT_W   = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [DATA_W-1:0]  push_data_i,
  input  logic               pop_i,
  output logic [DATA_W-1:0]  head_o,
  output logic [COUNT_W-1:0] count_o
);
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [COUNT_W-1:0] count_q;
  logic [DATA_W-1:0]  hold_q;
  logic               do_push, do_pop, not_empty;

  // Flush wins over push and pop; a push at full is only taken alongside a pop.
  always_comb begin
    not_empty = (count_q != '0);
    do_pop    = pop_i && not_empty && !flush_i;
    do_push   = push_i && !flush_i && ((count_q != COUNT_W'(FIFO_DEPTH)) || do_pop);
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + COUNT_W'(1);
        2'b01:   count_q <= count_q - COUNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array.
  // NOTE: the array has no reset; occupancy gates every read, so stale contents are never exposed as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Remember the current head so the output holds its last value once empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          hold_q <= '0;
    else if (not_empty) hold_q <= mem_q[rd_ptr_q];
  end

  assign head_o  = not_empty ? mem_q[rd_ptr_q] : hold_q;
  assign count_o = count_q;

endmodule

// File: rtl/lfsr_range_sampler.sv
// Mask-and-reject sampler turning LFSR words into uniform integers in [0, limit).
module lfsr_range_sampler
  import lfsr_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input logic                 clk,
  input logic                 reset,
  lfsr_range_sampler_if.slave bus
);
  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  limit_q, mask_q, cand, s1_data_q, head;
  logic [31:0]        mask_full;
  logic               accept, sample, has_credit, s1_valid_q, pop, unused_bits;
  logic [CNT_W-1:0]   reject_cnt_q;
  logic [COUNT_W-1:0] fifo_count;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FSM next state: a load pulse (re)enters LOAD, LOAD lasts one cycle.
  // NOTE: default assignment first, so no path leaves state_d unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (bus.limit_load)          state_d = ST_LOAD;
    else if (state_q == ST_LOAD) state_d = ST_RUN;
  end

  // FSM outputs.
  always_comb begin
    bus.busy = (state_q == ST_LOAD);
  end

  // Candidate, acceptance and credit check; only whole-word pieces are consumed.
  always_comb begin
    mask_full   = range_mask(32'(limit_q), DATA_W);
    cand        = bus.rand_in[DATA_W-1:0] & mask_q;
    accept      = (limit_q == '0) || (cand < limit_q);
    has_credit  = (int'(fifo_count) + int'(s1_valid_q)) < FIFO_DEPTH;
    sample      = (state_q == ST_RUN) && bus.rand_en && has_credit;
    pop         = bus.out_valid && bus.out_ready;
    unused_bits = ^{bus.rand_in, mask_full};
  end

  // Limit capture on load; mask derived during the single LOAD cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      limit_q <= '0;
      mask_q  <= '1;
    end else if (bus.limit_load) begin
      limit_q <= bus.limit;
    end else if (state_q == ST_LOAD) begin
      mask_q <= mask_full[DATA_W-1:0];
    end
  end

  // Stage 1: register accepted candidates; a load discards anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else if (bus.limit_load) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= sample && accept;
      if (sample) s1_data_q <= cand;
    end
  end

  // Saturating count of rejected candidates, cleared by a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          reject_cnt_q <= '0;
    else if (bus.limit_load)                            reject_cnt_q <= '0;
    else if (sample && !accept && (reject_cnt_q != '1)) reject_cnt_q <= reject_cnt_q + CNT_W'(1);
  end

  // Stage 2: accepted samples enter the output buffer.
  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.limit_load),
    .push_i      (s1_valid_q),
    .push_data_i (s1_data_q),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign bus.out_data   = head;
  assign bus.out_valid  = (fifo_count != '0);
  assign bus.reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Self-checking bench for lfsr_range_sampler with a queue-based reference model.
module tb_lfsr_range_sampler;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  lfsr_range_sampler_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  lfsr_range_sampler #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: queues of samples waiting one cycle and sitting in the buffer.
  int m_limit, m_mask, m_rej;
  bit m_loading;
  int m_stage[$];
  int m_fifo[$];

  function automatic int model_mask(input int lim);
    int m;
    if (lim == 0) return 16'hFFFF;
    m = 0;
    while (m < lim - 1) m = m * 2 + 1;
    return m;
  endfunction

  task automatic model_reset();
    m_limit = 0; m_mask = 16'hFFFF; m_rej = 0; m_loading = 1'b0;
    m_stage.delete(); m_fifo.delete();
  endtask

  task automatic model_step();
    bit sampled;
    int cand;
    if (bus.limit_load) begin
      m_limit = int'(bus.limit); m_loading = 1'b1; m_rej = 0;
      m_stage.delete(); m_fifo.delete();
      return;
    end
    sampled = !m_loading && bus.rand_en && ((m_fifo.size() + m_stage.size()) < FIFO_DEPTH);
    if (m_fifo.size() > 0 && bus.out_ready) void'(m_fifo.pop_front());
    if (m_stage.size() > 0) m_fifo.push_back(m_stage.pop_front());
    if (sampled) begin
      cand = int'(bus.rand_in[15:0]) & m_mask;
      if (m_limit == 0 || cand < m_limit) m_stage.push_back(cand);
      else if (m_rej < CNT_MAX) m_rej++;
    end
    if (m_loading) begin
      m_mask = model_mask(m_limit);
      m_loading = 1'b0;
    end
  endtask

  // Advance one clock with the model in lockstep; sample 1 ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_limit(input logic [15:0] lim);
    bus.limit = lim; bus.limit_load = 1'b1;
    tick();
    bus.limit_load = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] words [4];
    words = '{32'h3, 32'h5, 32'hF, 32'h7};
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.reject_cnt !== 4'h0) begin failures++; $display("FAIL reset_reject_cnt got=%h exp=0", bus.reject_cnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
    load_limit(16'd9);
    bus.out_ready = 1'b0; bus.rand_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rand_in = {16'($urandom), words[i][15:0]};
      tick();
    end
    bus.rand_en = 1'b0;
    tick(); tick();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL prereset_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.reject_cnt !== 4'h1) begin failures++; $display("FAIL prereset_rej got=%h exp=1", bus.reject_cnt); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.reject_cnt !== 4'h0) begin failures++; $display("FAIL async_reset_rej got=%h exp=0", bus.reject_cnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", bus.busy); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
    bus.rand_in = 32'h0000ACE1; bus.rand_en = 1'b1;
    tick();
    bus.rand_en = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ace1_early got=%b exp=0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hACE1) begin failures++; $display("FAIL ace1_sample got=%b/%h exp=1/ace1", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_range();
    logic [15:0] lows [4];
    logic [15:0] got [$];
    lows = '{16'h0003, 16'h000C, 16'h0009, 16'h001F};
    bus.out_ready = 1'b1; bus.rand_en = 1'b0;
    bus.limit = 16'd10; bus.limit_load = 1'b1;
    tick();
    bus.limit_load = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL range_busy_on got=%b exp=1", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL range_flush got=%b exp=0", bus.out_valid); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL range_busy_off got=%b exp=0", bus.busy); end
    for (int i = 0; i < 8; i++) begin
      bus.rand_en = (i < 4);
      bus.rand_in = {16'($urandom), lows[i % 4]};
      tick();
      if (bus.out_valid) got.push_back(bus.out_data);
    end
    checks++;
    if (got.size() != 2 || got[0] !== 16'd3 || got[1] !== 16'd9) begin
      failures++; $display("FAIL range_outputs got=%p exp='{3,9}", got);
    end
    checks++; if (bus.reject_cnt !== 4'd2) begin failures++; $display("FAIL range_rejects got=%0d exp=2", bus.reject_cnt); end
  endtask

  task automatic test_edge_limits();
    logic [15:0] got [$];
    logic [15:0] exp [$];
    int nonzero;
    bus.out_ready = 1'b1;
    load_limit(16'd1);
    nonzero = 0;
    for (int i = 0; i < 12; i++) begin
      bus.rand_en = (i < 8); bus.rand_in = $urandom;
      tick();
      if (bus.out_valid) got.push_back(bus.out_data);
    end
    foreach (got[i]) if (got[i] != 16'd0) nonzero++;
    checks++; if (got.size() != 8 || nonzero != 0) begin failures++; $display("FAIL limit1_samples got=%0d samples/%0d nonzero exp=8/0", got.size(), nonzero); end
    checks++; if (bus.reject_cnt !== 4'd0) begin failures++; $display("FAIL limit1_rejects got=%0d exp=0", bus.reject_cnt); end
    got.delete();
    load_limit(16'h8000);
    for (int i = 0; i < 12; i++) begin
      bus.rand_en = (i < 8); bus.rand_in = $urandom;
      if (i < 8) exp.push_back(bus.rand_in[15:0] & 16'h7FFF);
      tick();
      if (bus.out_valid) got.push_back(bus.out_data);
    end
    checks++; if (got != exp) begin failures++; $display("FAIL limit8000_samples got=%p exp=%p", got, exp); end
    checks++; if (bus.reject_cnt !== 4'd0) begin failures++; $display("FAIL limit8000_rejects got=%0d exp=0", bus.reject_cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [10];
    bus.out_ready = 1'b0;
    load_limit(16'd0);
    bus.rand_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w[i] = $urandom; bus.rand_in = w[i];
      tick();
    end
    bus.rand_en = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== w[0][15:0]) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/%h", bus.out_valid, bus.out_data, w[0][15:0]); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== w[i][15:0]) begin
        failures++; $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_data, w[i][15:0]);
      end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    load_limit(16'd0);
    bus.rand_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rand_in = $urandom;
      tick();
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_prefill got=%b exp=1", bus.out_valid); end
    bus.limit = 16'd1000; bus.limit_load = 1'b1; bus.rand_in = $urandom;
    tick();
    bus.limit_load = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL flush_next got=%b/%b exp=0/1", bus.out_valid, bus.busy); end
    bus.rand_in = {16'($urandom), 16'h0042};
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL flush_load_cycle got=%b/%b exp=0/0", bus.out_valid, bus.busy); end
    bus.rand_in = {16'($urandom), 16'h0123};
    tick();
    bus.rand_en = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_stage got=%b exp=0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0123) begin failures++; $display("FAIL flush_first_new got=%b/%h exp=1/0123", bus.out_valid, bus.out_data); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_leftover got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_saturation();
    logic [31:0] r;
    bus.out_ready = 1'b1;
    load_limit(16'd9);
    bus.rand_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      r = $urandom; r[3:0] = 4'(9 + $urandom_range(0, 6));
      bus.rand_in = r;
      tick();
      if (i == 13) begin
        checks++; if (bus.reject_cnt !== 4'd14) begin failures++; $display("FAIL sat_count14 got=%0d exp=14", bus.reject_cnt); end
      end
    end
    bus.rand_en = 1'b0;
    checks++; if (bus.reject_cnt !== 4'hF) begin failures++; $display("FAIL sat_hold got=%h exp=f", bus.reject_cnt); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL sat_no_out got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [15:0] lims [8];
    lims = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd10, 16'd100, 16'h8000, 16'd0};
    for (int c = 0; c < 800; c++) begin
      lims[7]        = 16'($urandom);
      bus.limit_load = ($urandom_range(0, 39) == 0);
      bus.limit      = lims[$urandom_range(0, 7)];
      bus.rand_en    = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      bus.rand_in    = $urandom;
      tick();
      checks++; if (bus.out_valid !== (m_fifo.size() > 0)) begin failures++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, bus.out_valid, m_fifo.size() > 0); end
      if (m_fifo.size() > 0) begin
        checks++; if (bus.out_data !== 16'(m_fifo[0])) begin failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, bus.out_data, 16'(m_fifo[0])); end
      end
      checks++; if (bus.reject_cnt !== 4'(m_rej)) begin failures++; $display("FAIL rand_rej c=%0d got=%0d exp=%0d", c, bus.reject_cnt, m_rej); end
      checks++; if (bus.busy !== m_loading) begin failures++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, bus.busy, m_loading); end
    end
    bus.limit_load = 1'b0; bus.rand_en = 1'b0;
  endtask

  initial begin
    bus.rand_in = '0; bus.rand_en = 1'b0; bus.limit = '0; bus.limit_load = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_range();
    test_edge_limits();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/lfsr_range_sampler.md
Name: lfsr_range_sampler

Overview:
Consumer stage placed directly downstream of the 32-bit LFSR generator. Takes the LFSR word each cycle it advances and produces unbiased uniform integers in [0, limit) by mask-and-reject sampling. Accepted samples are buffered in a small FIFO behind a valid/ready interface for downstream logic such as game or test-pattern engines.

Parameters:
DATA_W, 16, output sample width and limit width (1..32)
FIFO_DEPTH, 4, sample buffer depth; power of two, >= 2
CNT_W, 16, width of the saturating reject counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rand_in  in  32  LFSR word; treated as raw unsigned bits
rand_en  in  1  rand_in holds a fresh word this cycle
limit  in  DATA_W  exclusive upper bound; 0 means full 2^DATA_W range
limit_load  in  1  single-cycle pulse: latch limit and flush the pipeline
out_data  out  DATA_W  sample at FIFO head
out_valid  out  1  FIFO is non-empty
out_ready  in  1  downstream consumes the head when out_valid && out_ready
reject_cnt  out  CNT_W  count of rejected candidates; saturates at all ones
busy  out  1  high while in LOAD state

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, reject_cnt=0, busy=0.
  - limit_q=0, mask_q=all ones, FIFO empty, stage-1 invalid, state=RUN.
- States:
  - RUN -> LOAD on limit_load. Latch limit_q, flush stage-1 and the FIFO, clear reject_cnt.
  - LOAD -> RUN after exactly 1 cycle. Register mask_q = smallest 2^k-1 >= limit_q-1 (k>=0).
  - limit_q=0 gives mask all ones. limit_q=1 gives mask 0.
  - limit_load seen in LOAD restarts LOAD with the new limit.
- Candidate:
  - cand = rand_in[DATA_W-1:0] & mask_q.
  - accept = (limit_q==0) || (cand < limit_q), compared as unsigned.
- Sampling condition: state==RUN && rand_en && (fifo_count + s1_valid) < FIFO_DEPTH, which is credit-based.
  - Words that arrive while the condition is false are dropped. They are not counted as rejects.
- Stage 1 (edge N):
  - Register cand and accept into s1_data/s1_valid. s1_valid = sampled && accept.
  - If sampled && !accept, increment reject_cnt (saturating).
- Stage 2 (edge N+1): if s1_valid, push s1_data into the FIFO.
  - out_valid rises after edge N+1. Latency from rand_in to out_valid is 2 cycles.
- FIFO:
  - Show-ahead: out_data always equals the head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle is legal at any occupancy, including full.
  - The credit rule means no overflow ever occurs.
  - out_data holds its last value when empty. Its value is don't-care when out_valid=0.
- limit_load precedence: a flush has priority over a push or pop in the same cycle.
  - out_valid=0 from the next cycle.
  - No sample computed under the old limit may appear afterwards.
- Reset asserted mid-operation returns all state to reset values immediately. No samples survive.
- rand_in is sign-agnostic. Bit patterns are used unchanged.

Decomposition:
- Shared package lfsr_pkg:
  - State enum {RUN, LOAD}.
  - Default DATA_W and FIFO_DEPTH constants.
  - Function range_mask(limit, width), which returns the smallest all-ones mask covering limit-1.
- One sub-module: sample_fifo.
  - Synchronous show-ahead FIFO with flush, count output, DATA_W/FIFO_DEPTH parameters, and the same clk/reset.

Test Plan:
- Reset:
  - Stimulus: assert reset mid-stream with FIFO holding 3 entries.
  - Required: out_valid=0, reject_cnt=0, busy=0 asynchronously. With limit_q=0 after release, rand_in=32'h0000ACE1 with rand_en gives out_data=16'hACE1 two cycles later.
- Range:
  - Stimulus: limit_load with limit=10 (mask 4'hF), then rand_in low bits 0x0003, 0x000C, 0x0009, 0x001F.
  - Required: outputs 3 and 9 only, reject_cnt=2, busy high for exactly 1 cycle after the load.
- Edge limits:
  - limit=1: every accepted sample is 0, reject_cnt stays 0.
  - limit=16'h8000: mask 16'h7FFF, no rejects.
- Backpressure:
  - Stimulus: out_ready=0, rand_en=1 continuously with all candidates accepted.
  - Required: exactly FIFO_DEPTH=4 samples held in order and no further sampling. Raising out_ready drains in order, with a simultaneous push/pop at full.
- Flush:
  - Stimulus: limit_load with FIFO full and s1_valid=1.
  - Required: out_valid=0 the next cycle, and the first new sample is drawn from a rand_in word presented after LOAD.
- Saturation:
  - Stimulus: CNT_W=4 with more than 15 rejects (limit=9, candidates 9..15 repeated).
  - Required: reject_cnt holds 4'hF.
